ext_io_agent: RTL and testbench

- Models the external-world side of the processor's four 8-bit I/O ports.
- Drives InpExtWorld1..4 from host writes.
- Monitors OutExtWorld1..4 for value changes, coalesces them per port and queues {port, data} events in a FIFO.
- The host reads the FIFO over a valid/ready handshake. Used as the bench/host-side bridge around RISCprocessor.

---
 rtl/ext_io_agent.sv | 143 ++++++++++++++
 tb/tb_ext_io_agent.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_io_agent.sv
// Host-side bridge for the four 8-bit processor I/O ports. It drives the input ports from host
// writes and reports changes on the output ports through a first-word fall-through event FIFO.
module ext_io_agent #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [7:0]       OutExtWorld1,
  input  logic [7:0]       OutExtWorld2,
  input  logic [7:0]       OutExtWorld3,
  input  logic [7:0]       OutExtWorld4,
  output logic [7:0]       InpExtWorld1,
  output logic [7:0]       InpExtWorld2,
  output logic [7:0]       InpExtWorld3,
  output logic [7:0]       InpExtWorld4,
  input  logic             host_wr_valid,
  input  logic [1:0]       host_wr_port,
  input  logic [7:0]       host_wr_data,
  output logic             host_wr_ready,
  output logic             host_rd_valid,
  input  logic             host_rd_ready,
  output logic [1:0]       host_rd_port,
  output logic [7:0]       host_rd_data,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       out_vec    [4];
  logic [7:0]       inp_reg    [4];
  logic [7:0]       shadow_reg [4];
  logic [7:0]       pdata_reg  [4];
  logic             pend_reg   [4];
  logic [3:0]       pend_vec;
  logic [3:0]       change;
  logic [3:0]       drain;
  logic             push;
  logic [1:0]       push_port;
  logic             pop;
  logic             full;
  logic             overflow_hit;
  logic             wr_ready_reg;
  logic             overflow_reg;
  logic [9:0]       mem [FIFO_DEPTH];
  logic [9:0]       head;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  assign out_vec[0]   = OutExtWorld1;
  assign out_vec[1]   = OutExtWorld2;
  assign out_vec[2]   = OutExtWorld3;
  assign out_vec[3]   = OutExtWorld4;
  assign InpExtWorld1 = inp_reg[0];
  assign InpExtWorld2 = inp_reg[1];
  assign InpExtWorld3 = inp_reg[2];
  assign InpExtWorld4 = inp_reg[3];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port
      assign change[gi]   = out_vec[gi] != shadow_reg[gi];
      assign pend_vec[gi] = pend_reg[gi];

      // A fresh change wins over a drain: the port stays pending with the newer value.
      always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
          shadow_reg[gi] <= '0;
          pdata_reg[gi]  <= '0;
          pend_reg[gi]   <= 1'b0;
          inp_reg[gi]    <= '0;
        end else begin
          if (change[gi]) begin
            shadow_reg[gi] <= out_vec[gi];
            pdata_reg[gi]  <= out_vec[gi];
            pend_reg[gi]   <= 1'b1;
          end else if (drain[gi]) begin
            pend_reg[gi]   <= 1'b0;
          end
          if (wr_ready_reg && host_wr_valid && host_wr_port == 2'(gi))
            inp_reg[gi] <= host_wr_data;
        end
      end
    end
  endgenerate

  // Lowest-index pending port wins; eligibility uses the pre-edge count, so nothing is pushed at full.
  always_comb begin
    push      = 1'b0;
    push_port = '0;
    drain     = '0;
    if (!full) begin
      for (int p = 3; p >= 0; p--) begin
        if (pend_vec[p]) begin
          push      = 1'b1;
          push_port = 2'(p);
        end
      end
    end
    if (push)
      drain[push_port] = 1'b1;
  end

  assign overflow_hit  = |(change & pend_vec & ~drain);
  assign full          = count_reg == CNT_W'(FIFO_DEPTH);
  assign host_rd_valid = count_reg != '0;
  assign pop           = host_rd_valid && host_rd_ready;
  assign head          = mem[rd_ptr_reg];
  assign host_rd_port  = host_rd_valid ? head[9:8] : '0;
  assign host_rd_data  = host_rd_valid ? head[7:0] : '0;
  assign fifo_count    = count_reg;
  assign overflow      = overflow_reg;
  assign host_wr_ready = wr_ready_reg;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {push_port, pdata_reg[push_port]};
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wr_ready_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ready_reg <= 1'b1;
      if (overflow_hit)
        overflow_reg <= 1'b1;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_ext_io_agent.sv
// Bench for ext_io_agent: write-port table, directed corner sequences and a randomized run,
// all compared every cycle against a queue-based event model.
module tb_ext_io_agent;
  localparam int DEPTH = 8;

  logic       clk;
  logic       Reset;
  logic [7:0] out_w [4];
  logic [7:0] inp_w [4];
  logic       host_wr_valid;
  logic [1:0] host_wr_port;
  logic [7:0] host_wr_data;
  logic       host_wr_ready;
  logic       host_rd_valid;
  logic       host_rd_ready;
  logic [1:0] host_rd_port;
  logic [7:0] host_rd_data;
  logic [3:0] fifo_count;
  logic       overflow;

  ext_io_agent #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
    .clk(clk), .Reset(Reset),
    .OutExtWorld1(out_w[0]), .OutExtWorld2(out_w[1]),
    .OutExtWorld3(out_w[2]), .OutExtWorld4(out_w[3]),
    .InpExtWorld1(inp_w[0]), .InpExtWorld2(inp_w[1]),
    .InpExtWorld3(inp_w[2]), .InpExtWorld4(inp_w[3]),
    .host_wr_valid(host_wr_valid), .host_wr_port(host_wr_port),
    .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .host_rd_port(host_rd_port), .host_rd_data(host_rd_data),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: event queue plus per-port last-seen value and one pending slot.
  logic [9:0] mq [$];
  logic [7:0] m_shadow [4];
  logic [7:0] m_pdata  [4];
  logic [7:0] m_inp    [4];
  bit         m_pend   [4];
  bit         m_ovf;
  bit         m_ready;

  typedef struct {
    logic       v;
    logic [1:0] port;
    logic [7:0] data;
    logic [7:0] e [4];
  } wr_vec_t;
  wr_vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int p = 0; p < 4; p++) begin
      m_shadow[p] = 8'h00;
      m_pdata[p]  = 8'h00;
      m_inp[p]    = 8'h00;
      m_pend[p]   = 1'b0;
    end
    m_ovf   = 1'b0;
    m_ready = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int pre;
    int src;
    if (Reset) begin
      model_reset();
      return;
    end
    pre = mq.size();
    src = -1;
    if (pre < DEPTH)
      for (int p = 3; p >= 0; p--)
        if (m_pend[p]) src = p;
    if (pre > 0 && host_rd_ready)
      void'(mq.pop_front());
    if (src >= 0) begin
      mq.push_back({2'(src), m_pdata[src]});
      m_pend[src] = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      if (out_w[p] != m_shadow[p]) begin
        if (m_pend[p]) m_ovf = 1'b1;
        m_pend[p]   = 1'b1;
        m_pdata[p]  = out_w[p];
        m_shadow[p] = out_w[p];
      end
    end
    if (m_ready && host_wr_valid)
      m_inp[host_wr_port] = host_wr_data;
    m_ready = 1'b1;
  endtask

  task automatic check_all();
    chk("count", int'(fifo_count), mq.size());
    chk("rd_valid", int'(host_rd_valid), int'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("rd_port", int'(host_rd_port), int'(mq[0][9:8]));
      chk("rd_data", int'(host_rd_data), int'(mq[0][7:0]));
    end else begin
      chk("rd_port_idle", int'(host_rd_port), 0);
      chk("rd_data_idle", int'(host_rd_data), 0);
    end
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("wr_ready", int'(host_wr_ready), int'(m_ready));
    for (int p = 0; p < 4; p++)
      chk($sformatf("inp%0d", p + 1), int'(inp_w[p]), int'(m_inp[p]));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] exp_d;
    Reset         = 1'b1;
    host_wr_valid = 1'b0;
    host_wr_port  = 2'd0;
    host_wr_data  = 8'h00;
    host_rd_ready = 1'b0;
    for (int p = 0; p < 4; p++) out_w[p] = 8'h00;
    model_reset();

    tbl[0] = '{v: 1'b1, port: 2'd2, data: 8'hA5, e: '{8'h00, 8'h00, 8'hA5, 8'h00}};
    tbl[1] = '{v: 1'b1, port: 2'd0, data: 8'h11, e: '{8'h11, 8'h00, 8'hA5, 8'h00}};
    tbl[2] = '{v: 1'b1, port: 2'd3, data: 8'hFF, e: '{8'h11, 8'h00, 8'hA5, 8'hFF}};
    tbl[3] = '{v: 1'b0, port: 2'd1, data: 8'h77, e: '{8'h11, 8'h00, 8'hA5, 8'hFF}};
    tbl[4] = '{v: 1'b1, port: 2'd1, data: 8'h5A, e: '{8'h11, 8'h5A, 8'hA5, 8'hFF}};
    tbl[5] = '{v: 1'b1, port: 2'd2, data: 8'h00, e: '{8'h11, 8'h5A, 8'h00, 8'hFF}};

    step();
    step();
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_wr_ready", int'(host_wr_ready), 0);
    chk("rst_valid", int'(host_rd_valid), 0);
    Reset = 1'b0;
    step();
    chk("wr_ready_up", int'(host_wr_ready), 1);

    // Host writes
    for (int i = 0; i < 6; i++) begin
      host_wr_valid = tbl[i].v;
      host_wr_port  = tbl[i].port;
      host_wr_data  = tbl[i].data;
      step();
      host_wr_valid = 1'b0;
      for (int p = 0; p < 4; p++)
        chk($sformatf("tbl%0d_inp%0d", i, p + 1), int'(inp_w[p]), int'(tbl[i].e[p]));
      $display("write v=%0d port=%0d data=0x%02h -> inp=%02h %02h %02h %02h",
               tbl[i].v, tbl[i].port, tbl[i].data, inp_w[0], inp_w[1], inp_w[2], inp_w[3]);
    end

    // Single change latency and pop
    out_w[1] = 8'h3C;
    step();
    chk("lat_valid_k", int'(host_rd_valid), 0);
    step();
    chk("lat_valid_k1", int'(host_rd_valid), 1);
    chk("lat_port", int'(host_rd_port), 1);
    chk("lat_data", int'(host_rd_data), 8'h3C);
    chk("lat_count", int'(fifo_count), 1);
    host_rd_ready = 1'b1;
    step();
    host_rd_ready = 1'b0;
    chk("pop_count", int'(fifo_count), 0);
    chk("pop_valid", int'(host_rd_valid), 0);

    // Simultaneous changes on two ports
    out_w[0] = 8'h11;
    out_w[3] = 8'h44;
    step();
    step();
    chk("dual_count1", int'(fifo_count), 1);
    chk("dual_port0", int'(host_rd_port), 0);
    chk("dual_data0", int'(host_rd_data), 8'h11);
    step();
    chk("dual_count2", int'(fifo_count), 2);
    chk("dual_ovf", int'(overflow), 0);
    host_rd_ready = 1'b1;
    step();
    chk("dual_port1", int'(host_rd_port), 3);
    chk("dual_data1", int'(host_rd_data), 8'h44);
    step();
    host_rd_ready = 1'b0;
    chk("dual_empty", int'(fifo_count), 0);

    // Fill to full and coalesce on port 3
    for (int i = 1; i <= 10; i++) begin
      out_w[2] = 8'(8'h80 + i);
      step();
    end
    step();
    step();
    chk("full_count", int'(fifo_count), 8);
    chk("full_ovf", int'(overflow), 1);
    chk("full_head", int'(host_rd_data), 8'h81);
    host_rd_ready = 1'b1;
    step();
    host_rd_ready = 1'b0;
    chk("full_pop_only", int'(fifo_count), 7);
    chk("full_head2", int'(host_rd_data), 8'h82);
    step();
    chk("full_refill", int'(fifo_count), 8);
    host_rd_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp_d = (j < 7) ? 8'(8'h82 + j) : 8'h8A;
      chk($sformatf("drain%0d_port", j), int'(host_rd_port), 2);
      chk($sformatf("drain%0d_data", j), int'(host_rd_data), int'(exp_d));
      $display("read port=%0d data=0x%02h", host_rd_port, host_rd_data);
      step();
    end
    host_rd_ready = 1'b0;
    chk("drain_empty", int'(fifo_count), 0);
    chk("ovf_sticky", int'(overflow), 1);

    // Asynchronous reset mid-operation
    host_wr_valid = 1'b1;
    host_wr_port  = 2'd0;
    host_wr_data  = 8'hFF;
    step();
    host_wr_valid = 1'b0;
    out_w[0] = 8'h22;
    out_w[1] = 8'h33;
    out_w[3] = 8'h55;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_count", int'(fifo_count), 3);
    chk("pre_rst_inp1", int'(inp_w[0]), 8'hFF);
    Reset = 1'b1;
    #1;
    chk("async_count", int'(fifo_count), 0);
    chk("async_valid", int'(host_rd_valid), 0);
    chk("async_port", int'(host_rd_port), 0);
    chk("async_data", int'(host_rd_data), 0);
    chk("async_ovf", int'(overflow), 0);
    chk("async_wr_ready", int'(host_wr_ready), 0);
    chk("async_inp1", int'(inp_w[0]), 0);
    model_reset();
    step();
    Reset = 1'b0;
    step();
    chk("rerep_valid_k", int'(host_rd_valid), 0);
    step();
    chk("rerep_valid", int'(host_rd_valid), 1);
    chk("rerep_port", int'(host_rd_port), 0);
    chk("rerep_data", int'(host_rd_data), 8'h22);
    step();
    step();
    step();
    chk("rerep_count", int'(fifo_count), 4);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 4; p++)
        if ($urandom_range(0, 3) == 0) out_w[p] = 8'($urandom);
      host_rd_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      host_wr_valid = 1'($urandom_range(0, 1));
      host_wr_port  = 2'($urandom);
      host_wr_data  = 8'($urandom);
      Reset         = (i == 250);
      step();
    end
    Reset         = 1'b0;
    host_wr_valid = 1'b0;
    host_rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("final_empty", int'(fifo_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
